// File: rtl/demux_capture_4ch.sv
// rtl/demux_capture_4ch.sv - four-channel MSB-first word assembler behind a 1-to-4 demux
// Completed words leave through one round-robin valid/ready port tagged with their channel.
module demux_capture_4ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_strobe,
  input  logic             a,
  input  logic             b,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  output logic             out_valid,
  output logic [1:0]       out_ch,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [3:0]       overrun,
  output logic             proto_err,
  input  logic             clr_err
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sr   [4];
  logic [WIDTH-1:0] hold [4];
  logic [CW-1:0]    cnt  [4];
  logic [3:0]       hf;
  logic [1:0]       rr;
  logic [1:0]       gnt;
  logic             lock;
  logic [1:0]       lock_ch;

  logic [1:0]       sel;
  logic [3:0]       line;
  logic             bit_in;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             xfer;
  logic             drain_sel;
  logic             proto_set;
  logic [3:0]       ovr_set;

  assign sel       = {a, b};
  assign line      = {D, C, B, A};
  assign bit_in    = line[sel];
  assign word      = {sr[sel][WIDTH-2:0], bit_in};
  assign done      = bit_strobe && (cnt[sel] == CW'(WIDTH - 1));
  assign xfer      = out_valid && out_ready;
  assign drain_sel = xfer && (gnt == sel);
  assign proto_set = bit_strobe && |(line & ~(4'b0001 << sel));
  assign ovr_set   = (done && hf[sel] && !drain_sel) ? (4'b0001 << sel) : 4'b0000;

  // A presented word is locked in place until accepted, so later loads on
  // channels closer to rr cannot steal the grant mid-handshake.
  always_comb begin
    gnt = rr;
    if (lock) begin
      gnt = lock_ch;
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (hf[rr + 2'(i)]) gnt = rr + 2'(i);
      end
    end
  end

  assign out_valid = |hf;
  assign out_ch    = out_valid ? gnt : 2'd0;
  assign out_data  = out_valid ? hold[gnt] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        sr[c]   <= '0;
        hold[c] <= '0;
        cnt[c]  <= '0;
      end
      hf        <= '0;
      rr        <= '0;
      lock      <= 1'b0;
      lock_ch   <= '0;
      overrun   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (xfer) begin
        hf[gnt] <= 1'b0;
        rr      <= gnt + 2'd1;
      end
      lock    <= out_valid && !out_ready;
      lock_ch <= gnt;
      if (bit_strobe) begin
        sr[sel] <= word;
        if (done) begin
          cnt[sel] <= '0;
          // Placed after the drain clear so a same-edge reload keeps hf set.
          if (!hf[sel] || drain_sel) begin
            hold[sel] <= word;
            hf[sel]   <= 1'b1;
          end
        end else begin
          cnt[sel] <= cnt[sel] + CW'(1);
        end
      end
      overrun   <= (overrun & ~{4{clr_err}}) | ovr_set;
      proto_err <= (proto_err & ~clr_err) | proto_set;
    end
  end

endmodule
